// File: rtl/instr_decode_pkg.sv
// Shared types for the MIPS-lite decode stage.
// Contents: the opcode enumeration, the fetched-word field layout,
// the register-index type, and the small decode helpers that classify
// opcodes and sign-extend the immediate.
package instr_decode_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,
    OP_ADDI = 6'd1,
    OP_SUB  = 6'd2,
    OP_SUBI = 6'd3,
    OP_MUL  = 6'd4,
    OP_MULI = 6'd5,
    OP_OR   = 6'd6,
    OP_ORI  = 6'd7,
    OP_AND  = 6'd8,
    OP_ANDI = 6'd9,
    OP_XOR  = 6'd10,
    OP_XORI = 6'd11,
    OP_LDW  = 6'd12,
    OP_STW  = 6'd13,
    OP_BZ   = 6'd14,
    OP_BEQ  = 6'd15,
    OP_JR   = 6'd16,
    OP_HALT = 6'd17
  } opcode_e;

  // The R-type rd field lives in imm[15:11].
  typedef struct packed {
    logic [5:0]  opcode;
    reg_idx_t    rs;
    reg_idx_t    rt;
    logic [15:0] imm;
  } instruct_t;

  // ALU ops alternate register/immediate form: even opcodes below LDW are R-type.
  function automatic logic is_rtype(input logic [5:0] op);
    return (op < 6'd12) && (op[0] == 1'b0);
  endfunction

  function automatic logic is_alu_imm(input logic [5:0] op);
    return (op < 6'd12) && (op[0] == 1'b1);
  endfunction

  function automatic logic [31:0] sext_imm(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/instr_decode_reg_file.sv
// Register file for the decode stage: two asynchronous read ports, one
// synchronous write port, r0 hardwired to zero.
// A write in flight is forwarded to a read of the same register so the
// decode stage sees the new value in the same cycle.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_rd_idx_a / o_rd_data_a     read port A
//   i_rd_idx_b / o_rd_data_b     read port B
//   i_wr_en, i_wr_idx, i_wr_data write port
module instr_decode_reg_file
  import instr_decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_IDX_W-1:0]  i_rd_idx_a,
  input  logic [REG_IDX_W-1:0]  i_rd_idx_b,
  input  logic                  i_wr_en,
  input  logic [REG_IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_rd_data_a,
  output logic [DATA_WIDTH-1:0] o_rd_data_b
);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  // Storage update: clear on reset, drop writes aimed at r0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (i_wr_en && (i_wr_idx != 5'd0)) begin
      r_regs[i_wr_idx] <= i_wr_data;
    end
  end

  // Read ports with write-through forwarding.
  always_comb begin
    o_rd_data_a = {DATA_WIDTH{1'b0}};
    o_rd_data_b = {DATA_WIDTH{1'b0}};
    if (i_rd_idx_a == 5'd0) begin
      o_rd_data_a = {DATA_WIDTH{1'b0}};
    end else if (i_wr_en && (i_wr_idx == i_rd_idx_a)) begin
      o_rd_data_a = i_wr_data;
    end else begin
      o_rd_data_a = r_regs[i_rd_idx_a];
    end
    if (i_rd_idx_b == 5'd0) begin
      o_rd_data_b = {DATA_WIDTH{1'b0}};
    end else if (i_wr_en && (i_wr_idx == i_rd_idx_b)) begin
      o_rd_data_b = i_wr_data;
    end else begin
      o_rd_data_b = r_regs[i_rd_idx_b];
    end
  end

endmodule

// File: rtl/instr_decode.sv
// Instruction-decode stage of the MIPS-lite 5-stage pipeline.
// Holds the IF/ID register and the register file, detects load-use and
// branch-operand hazards, resolves BZ/BEQ/JR, latches HALT and loads the
// ID/EX register for execute.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_instruction, i_pc               fetched word and its address
//   i_wb_en, i_wb_rd, i_wb_data       write-back port
//   i_ex_wr_en, i_ex_is_load, i_ex_rd destination of the instruction in EX
//   i_mem_wr_en, i_mem_rd             destination of the instruction in MEM
//   o_branch_taken, o_branch_addr     fetch redirect (combinational)
//   o_hazard_detected                 freeze fetch and IF/ID (combinational)
//   o_halt_signal                     stop fetch (sticky once HALT issues)
//   o_idex_*                          ID/EX register fields
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           i_instruction,
  input  logic [31:0]           i_pc,
  input  logic                  i_wb_en,
  input  logic [4:0]            i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_ex_wr_en,
  input  logic                  i_ex_is_load,
  input  logic [4:0]            i_ex_rd,
  input  logic                  i_mem_wr_en,
  input  logic [4:0]            i_mem_rd,
  output logic                  o_branch_taken,
  output logic [31:0]           o_branch_addr,
  output logic                  o_hazard_detected,
  output logic                  o_halt_signal,
  output logic                  o_idex_valid,
  output logic [5:0]            o_idex_opcode,
  output logic [4:0]            o_idex_rs,
  output logic [4:0]            o_idex_rt,
  output logic [4:0]            o_idex_rd,
  output logic [DATA_WIDTH-1:0] o_idex_rs_val,
  output logic [DATA_WIDTH-1:0] o_idex_rt_val,
  output logic [31:0]           o_idex_imm,
  output logic [31:0]           o_idex_pc,
  output logic                  o_idex_wr_en,
  output logic                  o_idex_is_load,
  output logic                  o_idex_is_store,
  output logic                  o_idex_halt
);

  instruct_t             r_ifid_instr;
  logic [31:0]           r_ifid_pc;
  logic                  r_ifid_valid;
  logic                  r_halted;

  logic                  r_idex_valid;
  logic [5:0]            r_idex_opcode;
  logic [4:0]            r_idex_rs, r_idex_rt, r_idex_rd;
  logic [DATA_WIDTH-1:0] r_idex_rs_val, r_idex_rt_val;
  logic [31:0]           r_idex_imm, r_idex_pc;
  logic                  r_idex_wr_en, r_idex_is_load, r_idex_is_store, r_idex_halt;

  logic [5:0]            w_op;
  logic [4:0]            w_rs, w_rt, w_rd, w_dest;
  logic [31:0]           w_imm, w_target;
  logic [DATA_WIDTH-1:0] w_rs_val, w_rt_val;
  logic                  w_is_rtype, w_is_alu_imm, w_is_known, w_uses_rt, w_is_branch, w_writes;
  logic                  w_rs_is_ex, w_rt_is_ex, w_rs_is_mem, w_rt_is_mem;
  logic                  w_load_use, w_ex_pending, w_mem_pending, w_hazard;
  logic                  w_halt_signal, w_issue;
  logic                  w_branch_taken;
  logic [31:0]           w_branch_addr;

  instr_decode_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_reg_file (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx_a  (w_rs),
    .i_rd_idx_b  (w_rt),
    .i_wr_en     (i_wb_en),
    .i_wr_idx    (i_wb_rd),
    .i_wr_data   (i_wb_data),
    .o_rd_data_a (w_rs_val),
    .o_rd_data_b (w_rt_val)
  );

  assign w_op         = r_ifid_instr.opcode;
  assign w_rs         = r_ifid_instr.rs;
  assign w_rt         = r_ifid_instr.rt;
  assign w_rd         = r_ifid_instr.imm[15:11];
  assign w_imm        = sext_imm(r_ifid_instr.imm);
  assign w_target     = r_ifid_pc + {w_imm[29:0], 2'b00};

  assign w_is_rtype   = is_rtype(w_op);
  assign w_is_alu_imm = is_alu_imm(w_op);
  // Unknown opcodes are NOPs and read no registers.
  assign w_is_known   = (w_op <= OP_HALT);
  assign w_uses_rt    = w_is_rtype | (w_op == OP_BEQ) | (w_op == OP_STW);
  assign w_is_branch  = (w_op == OP_BZ) | (w_op == OP_BEQ) | (w_op == OP_JR);
  assign w_dest       = w_is_rtype ? w_rd : w_rt;
  assign w_writes     = (w_is_rtype | w_is_alu_imm | (w_op == OP_LDW)) & (w_dest != 5'd0);

  assign w_rs_is_ex    = w_is_known & (w_rs == i_ex_rd);
  assign w_rt_is_ex    = w_uses_rt & (w_rt == i_ex_rd);
  assign w_rs_is_mem   = w_is_known & (w_rs == i_mem_rd);
  assign w_rt_is_mem   = w_uses_rt & (w_rt == i_mem_rd);
  assign w_load_use    = i_ex_is_load & (i_ex_rd != 5'd0) & (w_rs_is_ex | w_rt_is_ex);
  // Branches compare in ID, so any producer still in EX or MEM must drain first.
  assign w_ex_pending  = i_ex_wr_en & (i_ex_rd != 5'd0) & (w_rs_is_ex | w_rt_is_ex);
  assign w_mem_pending = i_mem_wr_en & (i_mem_rd != 5'd0) & (w_rs_is_mem | w_rt_is_mem);
  assign w_hazard      = r_ifid_valid & (w_load_use | (w_is_branch & (w_ex_pending | w_mem_pending)));

  // The combinational term stops fetch in the very cycle HALT sits in IF/ID.
  assign w_halt_signal = r_halted | (r_ifid_valid & (w_op == OP_HALT));
  assign w_issue       = r_ifid_valid & ~w_hazard & ~r_halted;

  // Branch resolution for BZ/BEQ/JR.
  always_comb begin
    w_branch_taken = 1'b0;
    w_branch_addr  = 32'd0;
    if (w_issue) begin
      case (w_op)
        OP_BZ: begin
          if (w_rs_val == {DATA_WIDTH{1'b0}}) begin
            w_branch_taken = 1'b1;
            w_branch_addr  = w_target;
          end else begin
            w_branch_taken = 1'b0;
            w_branch_addr  = 32'd0;
          end
        end
        OP_BEQ: begin
          if (w_rs_val == w_rt_val) begin
            w_branch_taken = 1'b1;
            w_branch_addr  = w_target;
          end else begin
            w_branch_taken = 1'b0;
            w_branch_addr  = 32'd0;
          end
        end
        OP_JR: begin
          w_branch_taken = 1'b1;
          w_branch_addr  = w_rs_val[31:0];
        end
        default: begin
          w_branch_taken = 1'b0;
          w_branch_addr  = 32'd0;
        end
      endcase
    end else begin
      w_branch_taken = 1'b0;
      w_branch_addr  = 32'd0;
    end
  end

  // IF/ID register: hold on halt/hazard, squash on taken branch, else load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (w_halt_signal || w_hazard) begin
      r_ifid_instr <= r_ifid_instr;
      r_ifid_pc    <= r_ifid_pc;
      r_ifid_valid <= r_ifid_valid;
    end else if (w_branch_taken) begin
      r_ifid_instr <= '0;
      r_ifid_pc    <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_ifid_instr <= i_instruction;
      r_ifid_pc    <= i_pc;
      r_ifid_valid <= 1'b1;
    end
  end

  // Sticky halt: set when HALT actually issues so it passes into ID/EX once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (w_issue && (w_op == OP_HALT)) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end

  // ID/EX register: bubble unless an instruction issues this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !w_issue) begin
      r_idex_valid    <= 1'b0;
      r_idex_opcode   <= 6'd0;
      r_idex_rs       <= 5'd0;
      r_idex_rt       <= 5'd0;
      r_idex_rd       <= 5'd0;
      r_idex_rs_val   <= {DATA_WIDTH{1'b0}};
      r_idex_rt_val   <= {DATA_WIDTH{1'b0}};
      r_idex_imm      <= 32'd0;
      r_idex_pc       <= 32'd0;
      r_idex_wr_en    <= 1'b0;
      r_idex_is_load  <= 1'b0;
      r_idex_is_store <= 1'b0;
      r_idex_halt     <= 1'b0;
    end else begin
      r_idex_valid    <= 1'b1;
      r_idex_opcode   <= w_op;
      r_idex_rs       <= w_rs;
      r_idex_rt       <= w_rt;
      r_idex_rd       <= w_dest;
      r_idex_rs_val   <= w_rs_val;
      r_idex_rt_val   <= w_rt_val;
      r_idex_imm      <= w_imm;
      r_idex_pc       <= r_ifid_pc;
      r_idex_wr_en    <= w_writes;
      r_idex_is_load  <= (w_op == OP_LDW);
      r_idex_is_store <= (w_op == OP_STW);
      r_idex_halt     <= (w_op == OP_HALT);
    end
  end

  assign o_branch_taken    = w_branch_taken;
  assign o_branch_addr     = w_branch_addr;
  assign o_hazard_detected = w_hazard;
  assign o_halt_signal     = w_halt_signal;
  assign o_idex_valid      = r_idex_valid;
  assign o_idex_opcode     = r_idex_opcode;
  assign o_idex_rs         = r_idex_rs;
  assign o_idex_rt         = r_idex_rt;
  assign o_idex_rd         = r_idex_rd;
  assign o_idex_rs_val     = r_idex_rs_val;
  assign o_idex_rt_val     = r_idex_rt_val;
  assign o_idex_imm        = r_idex_imm;
  assign o_idex_pc         = r_idex_pc;
  assign o_idex_wr_en      = r_idex_wr_en;
  assign o_idex_is_load    = r_idex_is_load;
  assign o_idex_is_store   = r_idex_is_store;
  assign o_idex_halt       = r_idex_halt;

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_wr_en, ex_is_load, mem_wr_en;
  logic [4:0]  ex_rd, mem_rd;
  logic        o_branch_taken, o_hazard_detected, o_halt_signal;
  logic [31:0] o_branch_addr;
  logic        o_idex_valid, o_idex_wr_en, o_idex_is_load, o_idex_is_store, o_idex_halt;
  logic [5:0]  o_idex_opcode;
  logic [4:0]  o_idex_rs, o_idex_rt, o_idex_rd;
  logic [31:0] o_idex_rs_val, o_idex_rt_val, o_idex_imm, o_idex_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP_W = 32'hFC00_0000;

  instr_decode #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst), .i_instruction(instruction), .i_pc(pc),
    .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_ex_wr_en(ex_wr_en), .i_ex_is_load(ex_is_load), .i_ex_rd(ex_rd),
    .i_mem_wr_en(mem_wr_en), .i_mem_rd(mem_rd),
    .o_branch_taken(o_branch_taken), .o_branch_addr(o_branch_addr),
    .o_hazard_detected(o_hazard_detected), .o_halt_signal(o_halt_signal),
    .o_idex_valid(o_idex_valid), .o_idex_opcode(o_idex_opcode),
    .o_idex_rs(o_idex_rs), .o_idex_rt(o_idex_rt), .o_idex_rd(o_idex_rd),
    .o_idex_rs_val(o_idex_rs_val), .o_idex_rt_val(o_idex_rt_val),
    .o_idex_imm(o_idex_imm), .o_idex_pc(o_idex_pc),
    .o_idex_wr_en(o_idex_wr_en), .o_idex_is_load(o_idex_is_load),
    .o_idex_is_store(o_idex_is_store), .o_idex_halt(o_idex_halt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int op, input int rd, input int rs, input int rt);
    logic [5:0] o; logic [4:0] d, s, t;
    o = op[5:0]; d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {o, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input logic [15:0] imm);
    logic [5:0] o; logic [4:0] s, t;
    o = op[5:0]; s = rs[4:0]; t = rt[4:0];
    return {o, s, t, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instruction = NOP_W; pc = 32'd0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    mem_wr_en = 1'b0; mem_rd = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] val);
    instruction = NOP_W;
    wb_en = 1'b1; wb_rd = idx[4:0]; wb_data = val;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [228:0] all_out;
    do_reset();
    rst = 1'b1;
    tick();
    all_out = {o_branch_taken, o_branch_addr, o_hazard_detected, o_halt_signal, o_idex_valid,
               o_idex_opcode, o_idex_rs, o_idex_rt, o_idex_rd, o_idex_rs_val, o_idex_rt_val,
               o_idex_imm, o_idex_pc, o_idex_wr_en, o_idex_is_load, o_idex_is_store, o_idex_halt};
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_state got %h want 0", all_out); end
    rst = 1'b0;
    instruction = enc_r(0, 3, 1, 2); pc = 32'h100;
    tick();
    instruction = NOP_W;
    tick();
    checks++;
    if ({o_idex_valid, o_idex_opcode, o_idex_rd} !== {1'b1, 6'd0, 5'd3}) begin
      errors++; $display("FAIL pre_reset_issue got %b/%0d/%0d want 1/0/3", o_idex_valid, o_idex_opcode, o_idex_rd);
    end
    #2 rst = 1'b1;
    #1;
    all_out = {o_branch_taken, o_branch_addr, o_hazard_detected, o_halt_signal, o_idex_valid,
               o_idex_opcode, o_idex_rs, o_idex_rt, o_idex_rd, o_idex_rs_val, o_idex_rt_val,
               o_idex_imm, o_idex_pc, o_idex_wr_en, o_idex_is_load, o_idex_is_store, o_idex_halt};
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_midrun got %h want 0", all_out); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_addi();
    instruction = enc_i(1, 1, 0, 16'd5); pc = 32'h0;
    tick();
    instruction = enc_i(1, 2, 1, 16'hFFFD); pc = 32'h4;
    tick();
    checks++;
    if ({o_idex_valid, o_idex_opcode, o_idex_rd, o_idex_imm, o_idex_wr_en} !== {1'b1, 6'd1, 5'd1, 32'd5, 1'b1}) begin
      errors++; $display("FAIL addi_fields got v%b op%0d rd%0d imm%h we%b want v1 op1 rd1 imm5 we1",
                         o_idex_valid, o_idex_opcode, o_idex_rd, o_idex_imm, o_idex_wr_en);
    end
    instruction = enc_r(0, 0, 1, 2); pc = 32'h8;
    tick();
    checks++;
    if ({o_idex_imm, o_idex_pc} !== {32'hFFFF_FFFD, 32'h4}) begin
      errors++; $display("FAIL addi_neg_imm got imm %h pc %h want fffffffd 4", o_idex_imm, o_idex_pc);
    end
    instruction = NOP_W;
    tick();
    checks++;
    if ({o_idex_valid, o_idex_wr_en} !== 2'b10) begin
      errors++; $display("FAIL dest_r0_no_write got v%b we%b want v1 we0", o_idex_valid, o_idex_wr_en);
    end
    tick();
    checks++;
    if ({o_idex_valid, o_idex_wr_en, o_idex_opcode} !== {1'b1, 1'b0, 6'd63}) begin
      errors++; $display("FAIL nop_decode got v%b we%b op%0d want v1 we0 op63", o_idex_valid, o_idex_wr_en, o_idex_opcode);
    end
  endtask

  task automatic test_load_use();
    instruction = enc_r(0, 3, 2, 1); pc = 32'h40;
    tick();
    instruction = NOP_W;
    ex_is_load = 1'b1; ex_wr_en = 1'b1; ex_rd = 5'd2;
    #2;
    checks++;
    if (o_hazard_detected !== 1'b1) begin errors++; $display("FAIL load_use_hazard got %b want 1", o_hazard_detected); end
    tick();
    checks++;
    if (o_idex_valid !== 1'b0) begin errors++; $display("FAIL load_use_bubble got %b want 0", o_idex_valid); end
    ex_is_load = 1'b0; ex_wr_en = 1'b0; ex_rd = 5'd0;
    #2;
    checks++;
    if (o_hazard_detected !== 1'b0) begin errors++; $display("FAIL load_use_release got %b want 0", o_hazard_detected); end
    tick();
    checks++;
    if ({o_idex_valid, o_idex_opcode, o_idex_rd, o_idex_pc} !== {1'b1, 6'd0, 5'd3, 32'h40}) begin
      errors++; $display("FAIL load_use_reissue got v%b op%0d rd%0d pc%h want v1 op0 rd3 pc40",
                         o_idex_valid, o_idex_opcode, o_idex_rd, o_idex_pc);
    end
  endtask

  task automatic test_branch();
    // BZ r4 waits while its producer is still in MEM, then resolves taken (r4 is 0).
    instruction = enc_i(14, 0, 4, 16'd3); pc = 32'h80;
    tick();
    instruction = NOP_W; mem_wr_en = 1'b1; mem_rd = 5'd4;
    #2;
    checks++;
    if ({o_hazard_detected, o_branch_taken} !== 2'b10) begin
      errors++; $display("FAIL bz_mem_hazard got hz%b bt%b want hz1 bt0", o_hazard_detected, o_branch_taken);
    end
    tick();
    mem_wr_en = 1'b0; mem_rd = 5'd0;
    #2;
    checks++;
    if ({o_hazard_detected, o_branch_taken, o_branch_addr} !== {2'b01, 32'h8C}) begin
      errors++; $display("FAIL bz_taken got hz%b bt%b addr %h want hz0 bt1 addr 8c", o_hazard_detected, o_branch_taken, o_branch_addr);
    end
    tick();
    write_reg(1, 32'd7);
    write_reg(2, 32'd7);
    instruction = enc_i(15, 2, 1, 16'hFFFE); pc = 32'h20;
    tick();
    instruction = enc_r(0, 4, 1, 2); pc = 32'h24;
    #2;
    checks++;
    if ({o_branch_taken, o_branch_addr} !== {1'b1, 32'h18}) begin
      errors++; $display("FAIL beq_taken got bt%b addr %h want bt1 addr 18", o_branch_taken, o_branch_addr);
    end
    tick();
    instruction = NOP_W;
    checks++;
    if ({o_idex_valid, o_idex_opcode, o_branch_taken} !== {1'b1, 6'd15, 1'b0}) begin
      errors++; $display("FAIL beq_issue got v%b op%0d bt%b want v1 op15 bt0", o_idex_valid, o_idex_opcode, o_branch_taken);
    end
    tick();
    checks++;
    if (o_idex_valid !== 1'b0) begin errors++; $display("FAIL beq_squash got %b want 0", o_idex_valid); end
    write_reg(2, 32'd9);
    instruction = enc_i(15, 2, 1, 16'hFFFE); pc = 32'h20;
    tick();
    instruction = enc_r(0, 4, 1, 2); pc = 32'h24;
    #2;
    checks++;
    if ({o_branch_taken, o_branch_addr} !== 33'd0) begin
      errors++; $display("FAIL beq_not_taken got bt%b addr %h want bt0 addr 0", o_branch_taken, o_branch_addr);
    end
    tick();
    instruction = NOP_W;
    tick();
    checks++;
    if ({o_idex_valid, o_idex_opcode, o_idex_rd, o_idex_pc} !== {1'b1, 6'd0, 5'd4, 32'h24}) begin
      errors++; $display("FAIL beq_no_bubble got v%b op%0d rd%0d pc%h want v1 op0 rd4 pc24",
                         o_idex_valid, o_idex_opcode, o_idex_rd, o_idex_pc);
    end
  endtask

  task automatic test_bypass();
    instruction = enc_r(0, 6, 5, 0); pc = 32'h60;
    tick();
    instruction = NOP_W;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    wb_en = 1'b0;
    checks++;
    if (o_idex_rs_val !== 32'h1234) begin errors++; $display("FAIL wb_bypass got %h want 1234", o_idex_rs_val); end
    write_reg(0, 32'hDEAD);
    instruction = enc_r(0, 6, 0, 5); pc = 32'h64;
    tick();
    instruction = NOP_W;
    tick();
    checks++;
    if ({o_idex_rs_val, o_idex_rt_val} !== {32'd0, 32'h1234}) begin
      errors++; $display("FAIL r0_write_dropped got rs %h rt %h want 0 1234", o_idex_rs_val, o_idex_rt_val);
    end
  endtask

  task automatic test_random();
    logic [31:0] m_regs [32];
    logic [31:0] m_word, m_pc, e_addr, rv_s, rv_t, e_rs_val, e_rt_val, e_imm, e_pc;
    logic        m_valid, e_hz, e_take, lu, bp, e_v, e_wr, e_ld, e_st, is_r, is_i, reads_rs, reads_rt;
    logic [5:0]  op, e_op;
    logic [4:0]  rs, rt, rd, e_rs, e_rt, e_dest;
    int          simm;
    do_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_word = 32'd0; m_pc = 32'd0; m_valid = 1'b0;
    for (int cyc = 0; cyc < 250; cyc++) begin
      op = 6'($urandom_range(0, 19));
      if (op == 6'd17) op = 6'd18;
      instruction = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)};
      pc = $urandom & 32'hFFFF_FFFC;
      wb_en = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 3));
      wb_data = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      ex_wr_en = 1'($urandom_range(0, 1)); ex_is_load = ($urandom_range(0, 3) == 0); ex_rd = 5'($urandom_range(0, 3));
      mem_wr_en = 1'($urandom_range(0, 1)); mem_rd = 5'($urandom_range(0, 3));
      #2;
      op = m_word[31:26]; rs = m_word[25:21]; rt = m_word[20:16]; rd = m_word[15:11];
      simm = $signed(m_word[15:0]);
      rv_s = (rs == 0) ? 32'd0 : ((wb_en && wb_rd == rs) ? wb_data : m_regs[rs]);
      rv_t = (rt == 0) ? 32'd0 : ((wb_en && wb_rd == rt) ? wb_data : m_regs[rt]);
      is_r = (op < 12) && (op % 2 == 0);
      is_i = (op < 12) && (op % 2 == 1);
      reads_rs = (op <= 17);
      reads_rt = is_r || op == 13 || op == 15;
      lu = ex_is_load && ex_rd != 0 && ((reads_rs && rs == ex_rd) || (reads_rt && rt == ex_rd));
      bp = (op >= 14 && op <= 16) &&
           ((ex_wr_en && ex_rd != 0 && (rs == ex_rd || (reads_rt && rt == ex_rd))) ||
            (mem_wr_en && mem_rd != 0 && (rs == mem_rd || (reads_rt && rt == mem_rd))));
      e_hz = m_valid && (lu || bp);
      e_take = 1'b0; e_addr = 32'd0;
      if (m_valid && !e_hz) begin
        if ((op == 14 && rv_s == 0) || (op == 15 && rv_s == rv_t)) begin
          e_take = 1'b1; e_addr = m_pc + 32'(simm * 4);
        end else if (op == 16) begin
          e_take = 1'b1; e_addr = rv_s;
        end
      end
      checks++;
      if ({o_hazard_detected, o_branch_taken, o_branch_addr, o_halt_signal} !== {e_hz, e_take, e_addr, 1'b0}) begin
        errors++; $display("FAIL rand_ctrl cyc %0d got hz%b bt%b addr %h halt%b want hz%b bt%b addr %h halt0",
                           cyc, o_hazard_detected, o_branch_taken, o_branch_addr, o_halt_signal, e_hz, e_take, e_addr);
      end
      e_v = m_valid && !e_hz;
      e_op = op; e_rs = rs; e_rt = rt; e_rs_val = rv_s; e_rt_val = rv_t; e_imm = 32'(simm); e_pc = m_pc;
      e_dest = is_r ? rd : rt;
      e_wr = (is_r || is_i || op == 12) && e_dest != 0;
      e_ld = (op == 12); e_st = (op == 13);
      if (!e_hz) begin
        if (e_take) m_valid = 1'b0;
        else begin m_word = instruction; m_pc = pc; m_valid = 1'b1; end
      end
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
      tick();
      checks++;
      if (o_idex_valid !== e_v) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", cyc, o_idex_valid, e_v); end
      if (e_v) begin
        checks++;
        if ({o_idex_opcode, o_idex_rs, o_idex_rt, o_idex_wr_en, o_idex_is_load, o_idex_is_store, o_idex_halt} !==
            {e_op, e_rs, e_rt, e_wr, e_ld, e_st, 1'b0}) begin
          errors++; $display("FAIL rand_decode cyc %0d got op%0d rs%0d rt%0d ctl%b%b%b%b want op%0d rs%0d rt%0d ctl%b%b%b0",
                             cyc, o_idex_opcode, o_idex_rs, o_idex_rt, o_idex_wr_en, o_idex_is_load, o_idex_is_store, o_idex_halt,
                             e_op, e_rs, e_rt, e_wr, e_ld, e_st);
        end
        checks++;
        if ({o_idex_rs_val, o_idex_rt_val, o_idex_imm, o_idex_pc} !== {e_rs_val, e_rt_val, e_imm, e_pc}) begin
          errors++; $display("FAIL rand_values cyc %0d got %h %h %h %h want %h %h %h %h", cyc,
                             o_idex_rs_val, o_idex_rt_val, o_idex_imm, o_idex_pc, e_rs_val, e_rt_val, e_imm, e_pc);
        end
        if (e_wr) begin
          checks++;
          if (o_idex_rd !== e_dest) begin errors++; $display("FAIL rand_dest cyc %0d got %0d want %0d", cyc, o_idex_rd, e_dest); end
        end
      end else begin
        checks++;
        if ({o_idex_wr_en, o_idex_is_load, o_idex_is_store, o_idex_halt} !== 4'b0000) begin
          errors++; $display("FAIL rand_bubble_ctl cyc %0d got %b%b%b%b want 0000", cyc,
                             o_idex_wr_en, o_idex_is_load, o_idex_is_store, o_idex_halt);
        end
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    instruction = enc_i(17, 0, 0, 16'd0); pc = 32'h40;
    tick();
    // BZ r0 would redirect fetch if anything behind HALT were allowed to decode.
    instruction = enc_i(14, 0, 0, 16'd1); pc = 32'h44;
    #2;
    checks++;
    if (o_halt_signal !== 1'b1) begin errors++; $display("FAIL halt_comb got %b want 1", o_halt_signal); end
    tick();
    checks++;
    if ({o_idex_valid, o_idex_halt, o_idex_pc, o_halt_signal} !== {2'b11, 32'h40, 1'b1}) begin
      errors++; $display("FAIL halt_issue got v%b h%b pc%h hs%b want v1 h1 pc40 hs1", o_idex_valid, o_idex_halt, o_idex_pc, o_halt_signal);
    end
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (o_branch_taken !== 1'b0) begin errors++; $display("FAIL halt_frozen_%0d got bt%b want 0", k, o_branch_taken); end
      tick();
      checks++;
      if ({o_idex_valid, o_idex_halt, o_idex_wr_en, o_halt_signal} !== 4'b0001) begin
        errors++; $display("FAIL halt_bubble_%0d got v%b h%b we%b hs%b want 0 0 0 1", k, o_idex_valid, o_idex_halt, o_idex_wr_en, o_halt_signal);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_addi();
    test_load_use();
    test_branch();
    test_bypass();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
